// File: rtl/bist_fault_ram.sv
// One-bit-wide RAM with injectable stuck-at and coupling faults on a victim cell for BIST checks.
// Optional macro BIST_FAULT_RAM_COUPLING_EN enables the aggressor/victim coupling fault (fault=11).
module bist_fault_ram #(
  parameter int AWIDTH     = 4,
  parameter int FAULT_ADDR = 5,
  parameter int AGGR_ADDR  = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [AWIDTH-1:0] wr_addr,
  input  logic              data_in,
  input  logic              re,
  input  logic [AWIDTH-1:0] rd_addr,
  input  logic [1:0]        fault,
  output logic              data_out,
  output logic              rd_valid,
  output logic [7:0]        fault_hits
);

  localparam int DEPTH = 1 << AWIDTH;
  localparam logic [AWIDTH-1:0] FA = AWIDTH'(FAULT_ADDR);

  if (AGGR_ADDR == FAULT_ADDR) begin : g_addr_chk
    $error("AGGR_ADDR must differ from FAULT_ADDR");
  end

  logic [DEPTH-1:0] mem;
  logic [DEPTH-1:0] mem_n;
  logic             shadow;
  logic             shadow_n;
  logic             stuck0;
  logic             stuck1;
  logic             rd_bit;
  logic             hit;

  assign stuck0 = (fault == 2'b01);
  assign stuck1 = (fault == 2'b10);

`ifdef BIST_FAULT_RAM_COUPLING_EN
  localparam logic [AWIDTH-1:0] AG = AWIDTH'(AGGR_ADDR);
  logic coup;
  logic aggr_flip;
  assign coup      = (fault == 2'b11);
  assign aggr_flip = coup && we && (wr_addr == AG)
                     && (data_in != mem[AG]);
`endif

  // Read sees the stored (pre-write) value with the stuck-at override.
  always_comb begin
    rd_bit = mem[rd_addr];
    if (rd_addr == FA && stuck0) begin
      rd_bit = 1'b0;
    end else if (rd_addr == FA && stuck1) begin
      rd_bit = 1'b1;
    end
  end

  always_comb begin
    hit = 1'b0;
    if (re && rd_addr == FA) begin
      if (stuck0 || stuck1) begin
        hit = (rd_bit != shadow);
      end
`ifdef BIST_FAULT_RAM_COUPLING_EN
      if (coup) begin
        hit = (mem[FA] != shadow);
      end
`endif
    end
  end

  // Coupling flip first so a direct victim write on the same edge wins.
  always_comb begin
    mem_n    = mem;
    shadow_n = shadow;
`ifdef BIST_FAULT_RAM_COUPLING_EN
    if (aggr_flip) begin
      mem_n[FA] = ~mem[FA];
    end
`endif
    if (we) begin
      mem_n[wr_addr] = data_in;
      if (wr_addr == FA) begin
        shadow_n = data_in;
        if (stuck0) begin
          mem_n[FA] = 1'b0;
        end else if (stuck1) begin
          mem_n[FA] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem        <= '0;
      shadow     <= 1'b0;
      data_out   <= 1'b0;
      rd_valid   <= 1'b0;
      fault_hits <= 8'd0;
    end else begin
      mem      <= mem_n;
      shadow   <= shadow_n;
      rd_valid <= re;
      if (re) begin
        data_out <= rd_bit;
      end
      if (hit && fault_hits != 8'hFF) begin
        fault_hits <= fault_hits + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_bist_fault_ram.sv
// Self-checking bench for bist_fault_ram: directed scenarios plus random
// traffic compared against a cell-array reference model.
module tb_bist_fault_ram;

`ifdef BIST_FAULT_RAM_COUPLING_EN
  localparam bit COUP = 1'b1;
`else
  localparam bit COUP = 1'b0;
`endif
  localparam int FA = 5;
  localparam int AG = 6;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       we = 1'b0;
  logic [3:0] wr_addr = '0;
  logic       data_in = 1'b0;
  logic       re = 1'b0;
  logic [3:0] rd_addr = '0;
  logic [1:0] fault = '0;
  logic       data_out;
  logic       rd_valid;
  logic [7:0] fault_hits;

  int checks = 0;
  int failures = 0;

  bit m_cell[16];
  bit m_shadow;
  bit m_dout;
  bit m_valid;
  int m_hits;

  bist_fault_ram dut (
    .clk(clk), .rst(rst), .we(we), .wr_addr(wr_addr),
    .data_in(data_in), .re(re), .rd_addr(rd_addr),
    .fault(fault), .data_out(data_out), .rd_valid(rd_valid),
    .fault_hits(fault_hits)
  );

  always #5 clk = ~clk;

  // Drive one edge worth of inputs, then advance the model by the spec rules.
  task automatic step(input bit r, input bit w, input int wa,
                      input bit d, input bit rd, input int ra,
                      input int f);
    bit v;
    bit coupled;
    bit old_aggr;
    @(negedge clk);
    rst = r; we = w; wr_addr = 4'(wa); data_in = d;
    re = rd; rd_addr = 4'(ra); fault = 2'(f);
    @(posedge clk);
    if (r) begin
      foreach (m_cell[i]) m_cell[i] = 0;
      m_shadow = 0; m_dout = 0; m_valid = 0; m_hits = 0;
    end else begin
      coupled = COUP && f == 3;
      m_valid = rd;
      if (rd) begin
        v = m_cell[ra];
        if (ra == FA && f == 1) v = 0;
        if (ra == FA && f == 2) v = 1;
        m_dout = v;
        if (ra == FA && (f == 1 || f == 2 || coupled) && v != m_shadow)
          m_hits = (m_hits < 255) ? m_hits + 1 : 255;
      end
      old_aggr = m_cell[AG];
      if (w) begin
        if (coupled && wa == AG && d != old_aggr)
          m_cell[FA] = !m_cell[FA];
        if (wa == FA) begin
          m_shadow = d;
          m_cell[FA] = (f == 1) ? 1'b0 : (f == 2) ? 1'b1 : d;
        end else begin
          m_cell[wa] = d;
        end
      end
    end
    #1;
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_reset();
    step(1, 1, 3, 1, 1, 3, 0);
    checks++;
    if (data_out !== 1'b0) begin
      failures++; $display("FAIL reset_dout got=%b exp=0", data_out);
    end
    checks++;
    if (rd_valid !== 1'b0) begin
      failures++; $display("FAIL reset_valid got=%b exp=0", rd_valid);
    end
    checks++;
    if (fault_hits !== 8'd0) begin
      failures++; $display("FAIL reset_hits got=%0d exp=0", fault_hits);
    end
  endtask

  task automatic test_fill_read();
    int pulses = 0;
    int bad = 0;
    step(1, 0, 0, 0, 0, 0, 0);
    for (int a = 0; a < 16; a++) step(0, 1, a, 1, 0, 0, 0);
    for (int a = 0; a < 16; a++) begin
      step(0, 0, 0, 0, 1, a, 0);
      if (rd_valid === 1'b1) pulses++;
      if (data_out !== 1'b1) begin
        bad++; $display("FAIL fill_read addr=%0d got=%b exp=1", a, data_out);
      end
    end
    idle();
    if (rd_valid === 1'b1) pulses++;
    checks++;
    if (bad != 0) failures++;
    checks++;
    if (pulses != 16) begin
      failures++; $display("FAIL fill_pulses got=%0d exp=16", pulses);
    end
    checks++;
    if (fault_hits !== 8'd0) begin
      failures++; $display("FAIL fill_hits got=%0d exp=0", fault_hits);
    end
  endtask

  task automatic test_stuck0();
    step(1, 0, 0, 0, 0, 0, 0);
    step(0, 1, 5, 1, 0, 0, 1);
    step(0, 1, 4, 1, 0, 0, 1);
    step(0, 0, 0, 0, 1, 5, 1);
    checks++;
    if (data_out !== 1'b0 || fault_hits !== 8'd1) begin
      failures++;
      $display("FAIL stuck0_victim got=%b/%0d exp=0/1", data_out, fault_hits);
    end
    step(0, 0, 0, 0, 1, 4, 1);
    checks++;
    if (data_out !== 1'b1) begin
      failures++; $display("FAIL stuck0_neighbour got=%b exp=1", data_out);
    end
  endtask

  task automatic test_stuck1_sat();
    int ones = 0;
    step(1, 0, 0, 0, 0, 0, 0);
    for (int a = 0; a < 16; a++) step(0, 1, a, 0, 0, 0, 2);
    for (int a = 0; a < 16; a++) begin
      step(0, 0, 0, 0, 1, a, 2);
      if (data_out === 1'b1) begin
        ones++;
        checks++;
        if (a != FA) begin
          failures++; $display("FAIL stuck1_addr got=1 at %0d exp=0", a);
        end
      end
    end
    checks++;
    if (ones != 1 || fault_hits !== 8'd1) begin
      failures++;
      $display("FAIL stuck1_scan ones=%0d hits=%0d exp=1/1", ones, fault_hits);
    end
    for (int i = 0; i < 300; i++) step(0, 0, 0, 0, 1, 5, 2);
    checks++;
    if (fault_hits !== 8'd255) begin
      failures++; $display("FAIL stuck1_sat got=%0d exp=255", fault_hits);
    end
  endtask

  task automatic test_coupling();
    bit e1 = COUP;
    step(1, 0, 0, 0, 0, 0, 0);
    step(0, 1, 6, 1, 0, 0, 3);
    step(0, 0, 0, 0, 1, 5, 3);
    checks++;
    if (data_out !== e1) begin
      failures++; $display("FAIL couple_flip got=%b exp=%b", data_out, e1);
    end
    step(0, 1, 6, 1, 0, 0, 3);
    step(0, 0, 0, 0, 1, 5, 3);
    checks++;
    if (data_out !== e1) begin
      failures++; $display("FAIL couple_same got=%b exp=%b", data_out, e1);
    end
    step(0, 1, 6, 0, 0, 0, 3);
    step(0, 0, 0, 0, 1, 5, 3);
    checks++;
    if (data_out !== 1'b0 || fault_hits !== 8'(m_hits)) begin
      failures++;
      $display("FAIL couple_back got=%b/%0d exp=0/%0d",
               data_out, fault_hits, m_hits);
    end
  endtask

  task automatic test_read_first();
    step(1, 0, 0, 0, 0, 0, 0);
    step(0, 1, 3, 1, 1, 3, 0);
    checks++;
    if (data_out !== 1'b0 || rd_valid !== 1'b1) begin
      failures++;
      $display("FAIL read_first got=%b/%b exp=0/1", data_out, rd_valid);
    end
    step(0, 0, 0, 0, 1, 3, 0);
    checks++;
    if (data_out !== 1'b1) begin
      failures++; $display("FAIL read_after got=%b exp=1", data_out);
    end
  endtask

  task automatic test_reset_burst();
    step(1, 0, 0, 0, 0, 0, 0);
    for (int a = 0; a < 16; a++) step(0, 1, a, 1, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 1, 5, 1);
    step(1, 1, 2, 0, 1, 5, 1);
    checks++;
    if (data_out !== 1'b0 || rd_valid !== 1'b0 || fault_hits !== 8'd0) begin
      failures++;
      $display("FAIL reset_burst got=%b/%b/%0d exp=0/0/0",
               data_out, rd_valid, fault_hits);
    end
  endtask

  task automatic test_random();
    int bad = 0;
    for (int i = 0; i < 1500; i++) begin
      step($urandom_range(0, 99) == 0, 1'($urandom), $urandom_range(0, 15),
           1'($urandom), 1'($urandom), $urandom_range(0, 15),
           $urandom_range(0, 3));
      if (data_out !== m_dout || rd_valid !== m_valid ||
          fault_hits !== 8'(m_hits)) begin
        bad++;
        if (bad <= 5)
          $display("FAIL random cyc=%0d got=%b/%b/%0d exp=%b/%b/%0d", i,
                   data_out, rd_valid, fault_hits, m_dout, m_valid, m_hits);
      end
    end
    checks++;
    if (bad != 0) failures++;
  endtask

  initial begin
    test_reset();
    test_fill_read();
    test_stuck0();
    test_stuck1_sat();
    test_coupling();
    test_read_first();
    test_reset_burst();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
